wb_core_initiator: RTL and testbench

//  Wishbone classic master that bridges the core's valid/ready load-store port onto the shared Wishbone bus.
//  - Sits between the core's data port and the bus interconnect/RAM slaves.
//  - Converts byte/half/word requests into wb_sel_o lane masks and lane-replicated write data.
//  - Aligns and extends read data; reports misaligned, illegal, bus-error and timeout conditions.

---
 rtl/wb_core_initiator_if.sv | 38 +++
 rtl/wb_core_initiator.sv | 130 +++++++++++++
 tb/tb_wb_core_initiator.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_core_initiator_if.sv
// rtl/wb_core_initiator_if.sv - core load/store port and Wishbone classic bus bundle
interface wb_core_initiator_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_we_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [31:0]           req_wdata_i;
    logic                  resp_valid_o;
    logic [31:0]           resp_rdata_o;
    logic                  resp_err_o;
    logic [ADDR_WIDTH-3:0] wb_adr_o;
    logic [31:0]           wb_dat_o;
    logic [31:0]           wb_dat_i;
    logic                  wb_we_o;
    logic [3:0]            wb_sel_o;
    logic                  wb_stb_o;
    logic                  wb_cyc_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport master (
        input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );
endinterface

// File: rtl/wb_core_initiator.sv
// rtl/wb_core_initiator.sv - Wishbone classic master for the core load/store port
module wb_core_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic                 wb_clk_i,
    input logic                 wb_rst_ni,
    wb_core_initiator_if.master bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t        state;
    logic [CW-1:0] tmo_cnt;
    logic [1:0]    lsb_q;
    logic [1:0]    size_q;
    logic          uns_q;

    logic          misalign;
    logic [3:0]    sel_n;
    logic [31:0]   dat_n;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    assign bus.req_ready_o = (state == IDLE);

    always_comb begin
        misalign = (bus.req_size_i == 2'd3)
                || (bus.req_size_i == 2'd1 && bus.req_addr_i[0])
                || (bus.req_size_i == 2'd2 && bus.req_addr_i[1:0] != 2'b00);
        case (bus.req_size_i)
            2'd0: begin
                sel_n = 4'b0001 << bus.req_addr_i[1:0];
                dat_n = {4{bus.req_wdata_i[7:0]}};
            end
            2'd1: begin
                sel_n = 4'b0011 << bus.req_addr_i[1:0];
                dat_n = {2{bus.req_wdata_i[15:0]}};
            end
            default: begin
                sel_n = 4'b1111;
                dat_n = bus.req_wdata_i;
            end
        endcase
    end

    // Load data is right-justified from the addressed lane, then extended per size.
    always_comb begin
        shifted = bus.wb_dat_i >> {lsb_q, 3'b000};
        case (size_q)
            2'd0:    load_data = uns_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state            <= IDLE;
            tmo_cnt          <= '0;
            lsb_q            <= 2'b00;
            size_q           <= 2'b00;
            uns_q            <= 1'b0;
            bus.wb_cyc_o     <= 1'b0;
            bus.wb_stb_o     <= 1'b0;
            bus.wb_we_o      <= 1'b0;
            bus.wb_sel_o     <= 4'h0;
            bus.wb_adr_o     <= '0;
            bus.wb_dat_o     <= 32'h0;
            bus.resp_valid_o <= 1'b0;
            bus.resp_err_o   <= 1'b0;
            bus.resp_rdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        if (misalign) begin
                            bus.resp_valid_o <= 1'b1;
                            bus.resp_err_o   <= 1'b1;
                            bus.resp_rdata_o <= 32'h0;
                            state            <= RESP;
                        end else begin
                            bus.wb_cyc_o <= 1'b1;
                            bus.wb_stb_o <= 1'b1;
                            bus.wb_we_o  <= bus.req_we_i;
                            bus.wb_adr_o <= bus.req_addr_i[ADDR_WIDTH-1:2];
                            bus.wb_sel_o <= sel_n;
                            bus.wb_dat_o <= dat_n;
                            lsb_q        <= bus.req_addr_i[1:0];
                            size_q       <= bus.req_size_i;
                            uns_q        <= bus.req_unsigned_i;
                            tmo_cnt      <= '0;
                            state        <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (bus.wb_err_i || bus.wb_ack_i) begin
                        bus.wb_cyc_o     <= 1'b0;
                        bus.wb_stb_o     <= 1'b0;
                        bus.wb_we_o      <= 1'b0;
                        bus.resp_valid_o <= 1'b1;
                        bus.resp_err_o   <= bus.wb_err_i;
                        bus.resp_rdata_o <= (bus.wb_err_i || bus.wb_we_o) ? 32'h0 : load_data;
                        state            <= RESP;
                    end else if (TIMEOUT != 0 && tmo_cnt == CW'(TIMEOUT - 1)) begin
                        bus.wb_cyc_o     <= 1'b0;
                        bus.wb_stb_o     <= 1'b0;
                        bus.wb_we_o      <= 1'b0;
                        bus.resp_valid_o <= 1'b1;
                        bus.resp_err_o   <= 1'b1;
                        bus.resp_rdata_o <= 32'h0;
                        state            <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    bus.resp_valid_o <= 1'b0;
                    bus.resp_err_o   <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_core_initiator.sv
// tb/tb_wb_core_initiator.sv - randomized bench with byte-level memory model and per-cycle compare
module tb_wb_core_initiator;
    localparam int TMO = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wb_core_initiator_if #(.ADDR_WIDTH(32)) bus ();

    wb_core_initiator #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0]  mem [256];
    logic        chk_en;
    logic        exp_ready, exp_cyc, exp_we, exp_rv, exp_err;
    logic [3:0]  exp_sel;
    logic [29:0] exp_adr;
    logic [31:0] exp_dat, exp_rdata;
    logic [3:0]  last_sel;
    logic [29:0] last_adr;
    logic [31:0] last_dat, last_rdata;
    logic        last_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("ready", 32'(bus.req_ready_o), 32'(exp_ready));
            chk("cyc", 32'(bus.wb_cyc_o), 32'(exp_cyc));
            chk("stb", 32'(bus.wb_stb_o), 32'(exp_cyc));
            chk("we", 32'(bus.wb_we_o), 32'(exp_we));
            chk("resp_valid", 32'(bus.resp_valid_o), 32'(exp_rv));
            if (exp_cyc) begin
                chk("sel", 32'(bus.wb_sel_o), 32'(exp_sel));
                chk("adr", 32'(bus.wb_adr_o), 32'(exp_adr));
                chk("dat_o", bus.wb_dat_o, exp_dat);
            end
            if (exp_rv) begin
                chk("resp_err", 32'(bus.resp_err_o), 32'(exp_err));
                chk("resp_rdata", bus.resp_rdata_o, exp_rdata);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic set_idle_exp();
        exp_ready = 1'b1; exp_cyc = 1'b0; exp_we = 1'b0; exp_rv = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [7:0] a;
        a = addr[7:0] & 8'hFC;
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    // Expected load value assembled byte by byte from the memory image.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb, input logic uns);
        logic [31:0] v;
        logic [7:0]  a;
        v = 32'h0;
        for (int i = 0; i < nb; i++) begin
            a = addr[7:0] + 8'(i);
            v = v | (32'(mem[a]) << (8 * i));
        end
        if (!uns && nb < 4 && v[8 * nb - 1])
            v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        return v;
    endfunction

    task automatic idle_cycle(input logic force_ack);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = $urandom;
        bus.wb_ack_i    = force_ack | ($urandom_range(0, 3) == 0);
        bus.wb_err_i    = ($urandom_range(0, 7) == 0);
        bus.wb_dat_i    = $urandom;
        set_idle_exp();
    endtask

    // kind: 0 ack, 1 err, 2 ack+err together, 3 no response (timeout). w: wait states before response.
    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int kind, input int w);
        int          nb, off, k;
        logic        mis;
        logic [3:0]  sel;
        logic [31:0] dat, rexp;
        nb  = 1 << size;
        off = int'(addr[1:0]);
        mis = (size == 2'd3) || (off % nb != 0);
        sel = 4'h0;
        dat = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) sel[i] = 1'b1;
            dat[8 * i +: 8] = wdata[8 * (i % nb) +: 8];
        end
        rexp = mis ? 32'h0 : model_load(addr, nb, uns);

        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_wdata_i    = wdata;
        bus.wb_ack_i       = ($urandom_range(0, 3) == 0);
        bus.wb_err_i       = ($urandom_range(0, 7) == 0);
        bus.wb_dat_i       = $urandom;
        set_idle_exp();

        if (mis) begin
            k = 0;
        end else begin
            k = (kind == 3) ? TMO : w + 1;
            for (int c = 1; c <= k; c++) begin
                @(negedge clk);
                bus.req_valid_i = 1'b0;
                bus.wb_ack_i    = (c == k) && (kind == 0 || kind == 2);
                bus.wb_err_i    = (c == k) && (kind == 1 || kind == 2);
                bus.wb_dat_i    = (c == k && kind == 0 && !we) ? mem_word(addr) : $urandom;
                exp_ready = 1'b0; exp_cyc = 1'b1; exp_we = we; exp_rv = 1'b0;
                exp_sel = sel; exp_adr = addr[31:2]; exp_dat = dat;
                if (c == 1) begin
                    #3;
                    last_sel = bus.wb_sel_o;
                    last_adr = bus.wb_adr_o;
                    last_dat = bus.wb_dat_o;
                end
            end
        end

        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.wb_ack_i    = ($urandom_range(0, 3) == 0);
        bus.wb_err_i    = ($urandom_range(0, 7) == 0);
        bus.wb_dat_i    = $urandom;
        exp_ready = 1'b0; exp_cyc = 1'b0; exp_we = 1'b0; exp_rv = 1'b1;
        exp_err   = mis || (kind != 0);
        exp_rdata = (exp_err || we) ? 32'h0 : rexp;
        #3;
        last_rdata = bus.resp_rdata_o;
        last_err   = bus.resp_err_o;

        if (!mis && kind == 0 && we)
            for (int i = 0; i < nb; i++) mem[addr[7:0] + 8'(i)] = wdata[8 * i +: 8];
    endtask

    task automatic reset_mid_bus();
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_0200;
        bus.req_we_i    = 1'b0;
        bus.req_size_i  = 2'd2;
        bus.wb_ack_i    = 1'b0;
        bus.wb_err_i    = 1'b0;
        set_idle_exp();
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        exp_ready = 1'b0; exp_cyc = 1'b1; exp_we = 1'b0; exp_rv = 1'b0;
        exp_sel = 4'hF; exp_adr = 30'h80; exp_dat = bus.req_wdata_i;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_cyc_async", 32'(bus.wb_cyc_o), 32'h0);
        chk("rst_stb_async", 32'(bus.wb_stb_o), 32'h0);
        chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'h0);
        @(negedge clk);
        set_idle_exp();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle_cycle(1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b0;
        bus.req_valid_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_we_i = 1'b0;
        bus.req_size_i = 2'd0; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'h0;
        bus.wb_dat_i = 32'h0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        set_idle_exp();
        exp_err = 1'b0; exp_sel = 4'h0; exp_adr = 30'h0; exp_dat = 32'h0; exp_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        #12;
        chk("reset_ready", 32'(bus.req_ready_o), 32'h1);
        chk("reset_cyc", 32'(bus.wb_cyc_o), 32'h0);
        chk("reset_sel", 32'(bus.wb_sel_o), 32'h0);
        chk("reset_adr", 32'(bus.wb_adr_o), 32'h0);
        chk("reset_dat", bus.wb_dat_o, 32'h0);
        chk("reset_rdata", bus.resp_rdata_o, 32'h0);
        chk("reset_resp_valid", 32'(bus.resp_valid_o), 32'h0);
        @(negedge clk);
        #3;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle_cycle(1'b0);

        do_txn(32'h100, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 0, 1);
        chk("t1_sel", 32'(last_sel), 32'hF);
        chk("t1_adr", 32'(last_adr), 32'h40);
        do_txn(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 0, 1);
        chk("t1_rdata", last_rdata, 32'hDEADBEEF);

        do_txn(32'h103, 1'b1, 2'd0, 1'b0, 32'h000000A5, 0, 1);
        chk("t2_dat", last_dat, 32'hA5A5A5A5);
        chk("t2_sel", 32'(last_sel), 32'h8);
        do_txn(32'h103, 1'b0, 2'd0, 1'b0, 32'h0, 0, 2);
        chk("t2_signed", last_rdata, 32'hFFFFFFA5);
        do_txn(32'h103, 1'b0, 2'd0, 1'b1, 32'h0, 0, 0);
        chk("t2_unsigned", last_rdata, 32'h000000A5);

        do_txn(32'h100, 1'b1, 2'd2, 1'b0, 32'h80010000, 0, 1);
        do_txn(32'h102, 1'b0, 2'd1, 1'b0, 32'h0, 0, 1);
        chk("t3_sel", 32'(last_sel), 32'hC);
        chk("t3_rdata", last_rdata, 32'hFFFF8001);
        do_txn(32'h101, 1'b0, 2'd1, 1'b0, 32'h0, 0, 1);
        chk("t3_misalign_err", 32'(last_err), 32'h1);

        do_txn(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 3, 0);
        chk("t4_timeout_err", 32'(last_err), 32'h1);
        chk("t4_timeout_rdata", last_rdata, 32'h0);
        do_txn(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, 0, 1);
        chk("t4_after_timeout", last_rdata, 32'h80010000);

        do_txn(32'h104, 1'b0, 2'd2, 1'b0, 32'h0, 2, 1);
        chk("t5_ack_err", 32'(last_err), 32'h1);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);

        reset_mid_bus();

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          r, kind;
            a  = {$urandom_range(0, 255) == 0 ? 24'($urandom) : 24'h0, 8'($urandom)};
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
            r    = $urandom_range(0, 15);
            kind = (r < 12) ? 0 : (r < 13) ? 1 : (r < 14) ? 2 : 3;
            do_txn(a, 1'($urandom), sz, 1'($urandom), $urandom, kind, $urandom_range(0, 3));
            for (int g = $urandom_range(0, 2); g > 0; g--) idle_cycle(1'b0);
        end

        idle_cycle(1'b0);
        @(negedge clk);
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
